gray_updown_counter: RTL

//   Parametrised Gray-code up/down counter, successor to the fixed 3-bit up-only Gray counter.

---
 rtl/gray_updown_counter.sv | 114 +++++++++++
 1 files changed

// File: rtl/gray_updown_counter.sv
// Gray-code up/down counter: binary count, derived Gray output, sticky
// over/underflow flags, parallel Gray load, wrap or saturate at the ends.
//
// Ports:
//   Clk       rising-edge clock
//   Reset_n   synchronous reset, active-low, overrides all inputs
//   En        count enable
//   Up        direction, 1 = increment, 0 = decrement
//   Load      parallel load strobe (priority over En)
//   LoadVal   Gray-coded load value
//   Clr       clears Overflow and Underflow (a coincident set wins)
//   Output    registered Gray count
//   Binary    registered binary count
//   Overflow  sticky, set on an up-count past MAX
//   Underflow sticky, set on a down-count past 0
//   Tc        combinational terminal-count strobe
module gray_updown_counter #(
  parameter int WIDTH = 3,
  parameter bit WRAP  = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             Clr,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Tc
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_ld_bin;
  logic [WIDTH-1:0] w_nxt_bin;
  logic [WIDTH-1:0] w_nxt_gray;
  logic             w_at_max;
  logic             w_at_min;
  logic             w_cnt;
  logic             w_cnt_up;
  logic             w_cnt_dn;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  // Prefix XOR from the MSB down.
  always_comb begin
    w_ld_bin = '0;
    w_ld_bin[WIDTH-1] = LoadVal[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      w_ld_bin[i] = w_ld_bin[i+1] ^ LoadVal[i];
    end
  end

  assign w_at_max  = (r_bin == MAX);
  assign w_at_min  = (r_bin == '0);
  assign w_cnt     = En & ~Load;
  assign w_cnt_up  = w_cnt & Up;
  assign w_cnt_dn  = w_cnt & ~Up;
  assign w_ovf_evt = w_cnt_up & w_at_max;
  assign w_unf_evt = w_cnt_dn & w_at_min;

  // Binary arithmetic wraps modulo 2^WIDTH on its own;
  // saturation just suppresses the step at the ends.
  always_comb begin
    w_nxt_bin = r_bin;
    unique case (1'b1)
      Load: w_nxt_bin = w_ld_bin;
      w_cnt_up: begin
        if (!(w_at_max && !WRAP)) begin
          w_nxt_bin = r_bin + ONE;
        end
      end
      w_cnt_dn: begin
        if (!(w_at_min && !WRAP)) begin
          w_nxt_bin = r_bin - ONE;
        end
      end
      default: w_nxt_bin = r_bin;
    endcase
  end

  assign w_nxt_gray = w_nxt_bin ^ (w_nxt_bin >> 1);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      r_bin  <= w_nxt_bin;
      r_gray <= w_nxt_gray;
      // A set event wins over a coincident clear.
      r_ovf  <= w_ovf_evt | (r_ovf & ~Clr);
      r_unf  <= w_unf_evt | (r_unf & ~Clr);
    end
  end

  assign Output    = r_gray;
  assign Binary    = r_bin;
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;
  assign Tc        = w_ovf_evt | w_unf_evt;

endmodule
